// File: rtl/ddr_port0_writer.sv
// ddr_port0_writer: packs per-pixel result words into MIG port-0 write bursts and flags frame completion.
// Define DDR_WR_DOUBLE_BUF_EN to ping-pong frames between BASE_ADDR and BASE_ADDR+FRAME_STRIDE.
module ddr_port0_writer #(
  parameter int          BURST_LEN    = 64,
  parameter logic [29:0] BASE_ADDR    = 30'd0,
  parameter logic [29:0] FRAME_STRIDE = 30'd5242880
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_calib_done,
  input  logic        frame_start,
  input  logic [19:0] total_pixels,
  input  logic [31:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        wr_en,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_mask,
  input  logic        wr_full,
  input  logic        wr_empty,
  output logic        cmd_en,
  output logic [2:0]  cmd_instr,
  output logic [5:0]  cmd_bl,
  output logic [29:0] cmd_byte_addr,
  input  logic        cmd_full,
  output logic        busy,
  output logic        frame_done,
  output logic        front_buf
);
  typedef enum logic [2:0] {CALIB, READY, FILL, CMD, DRAIN, DONE} state_t;
  state_t      state;
  logic [1:0]  calib_q;
  logic [19:0] total, pix_idx;
  logic [6:0]  burst_cnt;
  logic [29:0] frame_base, burst_addr;
  logic        nxt_buf, accept, last_word, frame_end;
  assign pix_ready = state == FILL && !wr_full && burst_cnt < 7'(BURST_LEN) && pix_idx < total;
  assign accept    = pix_valid && pix_ready;
  assign last_word = burst_cnt + 7'd1 == 7'(BURST_LEN) || pix_idx + 20'd1 == total;
  assign frame_end = state == DRAIN && wr_empty && pix_idx == total;
  assign busy      = state != READY && state != CALIB;
  assign wr_mask   = 4'b0000;
  assign cmd_instr = 3'b000;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state         <= CALIB;
      calib_q       <= '0;
      total         <= '0;
      pix_idx       <= '0;
      burst_cnt     <= '0;
      frame_base    <= BASE_ADDR;
      burst_addr    <= '0;
      wr_en         <= 1'b0;
      wr_data       <= '0;
      cmd_en        <= 1'b0;
      cmd_bl        <= '0;
      cmd_byte_addr <= '0;
      frame_done    <= 1'b0;
    end else begin
      calib_q    <= {calib_q[0], mem_calib_done};
      wr_en      <= accept;
      cmd_en     <= 1'b0;
      frame_done <= 1'b0;
      if (accept) wr_data <= pix_data;
      case (state)
        CALIB: if (calib_q[1]) state <= READY;
        READY: if (frame_start) begin
          total      <= total_pixels;
          pix_idx    <= '0;
          burst_cnt  <= '0;
          frame_base <= nxt_buf ? BASE_ADDR + FRAME_STRIDE : BASE_ADDR;
          frame_done <= total_pixels == '0;
          state      <= total_pixels == '0 ? DONE : FILL;
        end
        FILL: if (accept) begin
          pix_idx   <= pix_idx + 20'd1;
          burst_cnt <= burst_cnt + 7'd1;
          if (burst_cnt == '0) burst_addr <= frame_base + {8'd0, pix_idx, 2'b00};
          if (last_word) state <= CMD;
        end
        CMD: if (!cmd_full) begin
          cmd_en        <= 1'b1;
          cmd_bl        <= 6'(burst_cnt - 7'd1);
          cmd_byte_addr <= burst_addr;
          burst_cnt     <= '0;
          state         <= DRAIN;
        end
        DRAIN: if (wr_empty) begin
          frame_done <= frame_end;
          state      <= frame_end ? DONE : FILL;
        end
        default: state <= READY;
      endcase
    end
`ifdef DDR_WR_DOUBLE_BUF_EN
  logic cur_buf;
  // front_buf must change together with frame_done, including zero-pixel frames that skip DRAIN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      nxt_buf   <= 1'b0;
      cur_buf   <= 1'b0;
      front_buf <= 1'b0;
    end else if (state == READY && frame_start) begin
      nxt_buf <= !nxt_buf;
      cur_buf <= nxt_buf;
      if (total_pixels == '0) front_buf <= nxt_buf;
    end else if (frame_end) front_buf <= cur_buf;
`else
  assign nxt_buf   = 1'b0;
  assign front_buf = 1'b0;
`endif
endmodule
